imem_fetch_ctrl: RTL and testbench
==================================

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 Parameter DEPTH, default 16, is the number of 32-bit instruction words held; it is fixed at 16 and the index is 4 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
REQ-004 restart  input  1  synchronous request to discard the program and return to LOAD.
REQ-005 ld_valid  input  1  loader word valid.
REQ-006 ld_data  input  32  loader instruction word.
REQ-007 ld_last  input  1  marks the final word of the program; qualified by ld_valid.
REQ-008 ld_ready  output  1  controller accepts a loader word this cycle.
REQ-009 if_ready  input  1  fetch stage accepts the presented instruction.
REQ-010 if_valid  output  1  if_instr and if_pc are valid.
REQ-011 if_instr  output  32  fetched instruction word.
REQ-012 if_pc  output  32  byte address of if_instr.
REQ-013 br_taken  input  1  redirect request.
REQ-014 br_target  input  32  redirect byte address.
REQ-015 loaded_count  output  5  number of words loaded, range 0..16.
REQ-016 state  output  2  LOAD=0, RUN=1, HALT=2; 3 is never driven.
REQ-017 err_align  output  1  sticky flag for a misaligned redirect.

Function
REQ-018 Internal storage: 16x32 array mem, write index = loaded_count[3:0], fetch address register fetch_pc of 32 bits.
REQ-019 LOAD: ld_ready = 1 while loaded_count < 16; a word is accepted when ld_valid && ld_ready, which writes mem[loaded_count] and increments loaded_count.
REQ-020 LOAD exit: an accepted word with ld_last=1, or the acceptance that makes loaded_count = 16, moves to RUN on the same edge; fetch_pc is set to 0 and if_valid stays 0.
REQ-021 In RUN and HALT, ld_ready = 0 and mem is never written.
REQ-022 RUN priority: br_taken first, then the advance rule.
REQ-023 RUN branch: when br_taken=1, set fetch_pc to br_target and set if_valid to 0 on the next edge, which discards any presented instruction regardless of if_ready.
REQ-024 RUN advance: when !if_valid || if_ready, and fetch_pc[5:2] < loaded_count with fetch_pc[31:6] = 0, load if_instr with mem[fetch_pc[5:2]], load if_pc with fetch_pc, set if_valid to 1, and add 4 to fetch_pc.
REQ-025 RUN end: when !if_valid || if_ready and the fetch address is out of range, set if_valid to 0 and move to HALT.
REQ-026 RUN stall: when if_valid && !if_ready && !br_taken, if_instr, if_pc, if_valid and fetch_pc hold.
REQ-027 Read latency: the first if_valid rises 1 cycle after RUN entry; with if_ready held at 1, one instruction is delivered per cycle.
REQ-028 Misaligned redirect: br_taken with br_target[1:0] != 0 sets err_align to 1, sets if_valid to 0 and moves to HALT; the flag stays set until reset or restart.
REQ-029 HALT: if_valid = 0; br_taken and ld_valid are ignored; only restart or reset leave HALT.
REQ-030 restart=1, in any state, has priority over all other inputs: next state LOAD, loaded_count=0, if_valid=0, fetch_pc=0, err_align=0; mem contents are don't-care.
REQ-031 loaded_count saturates at 16; ld_ready is 0 at 16, so no write wraps around.
REQ-032 ld_last with loaded_count=0 is legal: RUN fetches exactly one word.

Reset
REQ-033 reset=0 asynchronously forces: state=LOAD, loaded_count=0, ld_ready=1 (once reset=1), if_valid=0, if_instr=0, if_pc=0, fetch_pc=0, err_align=0.
REQ-034 Reset asserted mid-load or mid-run aborts the operation; no partial state is retained except mem contents, which are don't-care.

Verification
REQ-035 Load 3 words 0x11,0x22,0x33, ld_last on 3rd, if_ready=1 -> state=RUN next cycle; if_instr 0x11/0x22/0x33 with if_pc 0/4/8 on consecutive cycles; then if_valid=0 and state=HALT.
REQ-036 Load 16 words without ld_last -> RUN after 16th; ld_ready=0; extra ld_valid is ignored and loaded_count=16.
REQ-037 RUN, if_ready=0 for 3 cycles while if_pc=4 -> outputs hold; on release the next if_pc=8 with no skip or duplicate.
REQ-038 br_taken, br_target=0x0C, while if_valid=1 and if_ready=0 -> if_valid=0 next cycle, then if_pc=0x0C; br_target=0x0D -> err_align=1 and state=HALT.
REQ-039 reset pulsed low mid-RUN -> all outputs take reset values without a clock edge; restart in HALT -> LOAD with loaded_count=0 and err_align=0.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction memory loader and in-order fetch controller
module imem_fetch_ctrl #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        restart,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  input  logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [4:0]  loaded_count,
  output logic [1:0]  state,
  output logic        err_align
);

  typedef enum logic [1:0] {LOAD = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

  state_t      st;
  logic [31:0] mem [DEPTH];
  logic [31:0] fetch_pc;
  logic        ld_accept;
  logic        in_range;
  logic        advance;

  assign state     = st;
  assign ld_ready  = (st == LOAD) && (loaded_count < 5'(DEPTH));
  assign ld_accept = ld_valid && ld_ready;
  assign in_range  = (fetch_pc[31:6] == 26'd0) && ({1'b0, fetch_pc[5:2]} < loaded_count);
  assign advance   = !if_valid || if_ready;

  // Storage carries no reset; its contents are meaningless until reloaded.
  always_ff @(posedge clk) begin
    if (ld_accept && !restart)
      mem[loaded_count[3:0]] <= ld_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st           <= LOAD;
      loaded_count <= 5'd0;
      fetch_pc     <= 32'd0;
      if_valid     <= 1'b0;
      if_instr     <= 32'd0;
      if_pc        <= 32'd0;
      err_align    <= 1'b0;
    end else if (restart) begin
      st           <= LOAD;
      loaded_count <= 5'd0;
      fetch_pc     <= 32'd0;
      if_valid     <= 1'b0;
      err_align    <= 1'b0;
    end else begin
      case (st)
        LOAD: begin
          if (ld_accept) begin
            loaded_count <= loaded_count + 5'd1;
            if (ld_last || (loaded_count == 5'(DEPTH - 1))) begin
              st       <= RUN;
              fetch_pc <= 32'd0;
              if_valid <= 1'b0;
            end
          end
        end
        RUN: begin
          if (br_taken) begin
            if_valid <= 1'b0;
            if (br_target[1:0] != 2'b00) begin
              err_align <= 1'b1;
              st        <= HALT;
            end else begin
              fetch_pc <= br_target;
            end
          end else if (advance) begin
            if (in_range) begin
              if_instr <= mem[fetch_pc[5:2]];
              if_pc    <= fetch_pc;
              if_valid <= 1'b1;
              fetch_pc <= fetch_pc + 32'd4;
            end else begin
              if_valid <= 1'b0;
              st       <= HALT;
            end
          end
        end
        default: begin
          if_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - randomized bench with a program-queue reference model
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        restart = 1'b0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_data = 32'd0;
  logic        ld_last = 1'b0;
  logic        ld_ready;
  logic        if_ready = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic [4:0]  loaded_count;
  logic [1:0]  state;
  logic        err_align;

  imem_fetch_ctrl #(.DEPTH(16)) dut (
    .clk(clk), .reset(reset), .restart(restart),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .if_ready(if_ready), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .br_taken(br_taken), .br_target(br_target),
    .loaded_count(loaded_count), .state(state), .err_align(err_align)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference: the loaded program is a queue; fetching walks byte addresses over it.
  logic [31:0] prog[$];
  int          m_mode;
  bit [31:0]   m_fpc;
  bit          m_iv;
  bit [31:0]   m_instr;
  bit [31:0]   m_pc;
  bit          m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    prog.delete();
    m_mode = 0; m_fpc = 0; m_iv = 0; m_instr = 0; m_pc = 0; m_err = 0;
  endtask

  task automatic model_step();
    if (restart) begin
      prog.delete();
      m_mode = 0; m_fpc = 0; m_iv = 0; m_err = 0;
      return;
    end
    if (m_mode == 0) begin
      if (ld_valid && prog.size() < 16) begin
        prog.push_back(ld_data);
        if (ld_last || prog.size() == 16) begin
          m_mode = 1; m_fpc = 0; m_iv = 0;
        end
      end
    end else if (m_mode == 1) begin
      if (br_taken) begin
        m_iv = 0;
        if (br_target % 4 != 0) begin
          m_err = 1; m_mode = 2;
        end else begin
          m_fpc = br_target;
        end
      end else if (!m_iv || if_ready) begin
        if (m_fpc < 4 * prog.size()) begin
          m_instr = prog[m_fpc / 4];
          m_pc    = m_fpc;
          m_iv    = 1;
          m_fpc   = m_fpc + 4;
        end else begin
          m_iv = 0; m_mode = 2;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    restart = 0; ld_valid = 0; ld_last = 0; ld_data = 0; br_taken = 0; br_target = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", 32'(state), 32'(m_mode));
      chk("loaded_count", 32'(loaded_count), 32'(prog.size()));
      chk("ld_ready", 32'(ld_ready), 32'(m_mode == 0 && prog.size() < 16));
      chk("if_valid", 32'(if_valid), 32'(m_iv));
      chk("err_align", 32'(err_align), 32'(m_err));
      if (m_iv) begin
        chk("if_instr", if_instr, m_instr);
        chk("if_pc", if_pc, m_pc);
      end
    end
  end

  initial begin
    model_reset();
    #3;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_count", 32'(loaded_count), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_err", 32'(err_align), 32'd0);
    #10 reset = 1'b1;
    chk("rst_ld_ready", 32'(ld_ready), 32'd1);
    chk_en = 1'b1;

    // Three-word program, free-running fetch.
    if_ready = 1;
    for (int i = 1; i <= 3; i++) begin
      ld_valid = 1; ld_data = 32'h11 * i; ld_last = (i == 3);
      cyc();
    end
    idle_inputs();
    chk("d35_run", 32'(state), 32'd1);
    chk("d35_iv0", 32'(if_valid), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("d35_instr", if_instr, 32'h11 * i);
      chk("d35_pc", if_pc, 32'(4 * (i - 1)));
    end
    cyc();
    chk("d35_end_iv", 32'(if_valid), 32'd0);
    chk("d35_halt", 32'(state), 32'd2);

    restart = 1; cyc(); restart = 0;
    chk("restart_state", 32'(state), 32'd0);

    // Full 16-word load without ld_last, then an extra offered word.
    for (int i = 0; i < 16; i++) begin
      ld_valid = 1; ld_data = 32'h100 + i; ld_last = 0;
      cyc();
    end
    chk("d36_run", 32'(state), 32'd1);
    chk("d36_ld_ready", 32'(ld_ready), 32'd0);
    cyc();
    idle_inputs();
    chk("d36_count", 32'(loaded_count), 32'd16);
    chk("d36_first", if_instr, 32'h100);
    cyc();
    chk("d37_pc4", if_pc, 32'd4);
    if_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("d37_hold_pc", if_pc, 32'd4);
      chk("d37_hold_instr", if_instr, 32'h101);
    end
    if_ready = 1;
    cyc();
    chk("d37_release_pc", if_pc, 32'd8);
    if_ready = 0;
    br_taken = 1; br_target = 32'h0C;
    cyc();
    br_taken = 0;
    chk("d38_flush", 32'(if_valid), 32'd0);
    cyc();
    chk("d38_target_pc", if_pc, 32'h0C);
    chk("d38_target_instr", if_instr, 32'h103);
    br_taken = 1; br_target = 32'h0D;
    cyc();
    br_taken = 0;
    chk("d38_err", 32'(err_align), 32'd1);
    chk("d38_halt", 32'(state), 32'd2);

    restart = 1; cyc(); restart = 0;
    chk("d39_err_clr", 32'(err_align), 32'd0);
    chk("d39_count", 32'(loaded_count), 32'd0);

    // Single word with ld_last, then reset mid-run.
    if_ready = 1;
    ld_valid = 1; ld_data = 32'hCAFE; ld_last = 1;
    cyc();
    idle_inputs();
    cyc();
    chk("d32_one", if_instr, 32'hCAFE);
    #2 reset = 0;
    model_reset();
    #1;
    chk("d39_async_state", 32'(state), 32'd0);
    chk("d39_async_iv", 32'(if_valid), 32'd0);
    chk("d39_async_instr", if_instr, 32'd0);
    chk("d39_async_pc", if_pc, 32'd0);
    #4 reset = 1;

    for (int n = 0; n < 4000; n++) begin
      restart   = ($urandom_range(0, 63) == 0);
      ld_valid  = ($urandom_range(0, 3) != 0);
      ld_data   = $urandom;
      ld_last   = ($urandom_range(0, 5) == 0);
      if_ready  = ($urandom_range(0, 9) < 7);
      br_taken  = ($urandom_range(0, 7) == 0);
      br_target = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(0, 80))
                                               : 32'(4 * $urandom_range(0, 20));
      cyc();
    end
    idle_inputs();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
